// File: rtl/ptr_reader.sv
// PR-2 photoelectric tape reader model.
// Plays a tape image held in internal RAM forward as strobed 5-bit frames,
// or backs the tape up to the previous stop code on a reverse command.
// Motor timing is modelled with a start delay and a fixed per-frame period.
module ptr_reader #(
    parameter int          DEPTH      = 4096,
    parameter int          FRAME_CLKS = 80000,
    parameter int          START_CLKS = 20000,
    parameter logic [4:0]  STOP_CODE  = 5'h10,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic          CLOCK,
    input  logic          rst,
    input  logic          PL6_PHOTO_TAPE_FWD,
    input  logic          REV_CMD,
    input  logic          REWIND,
    input  logic          LOAD_WE,
    input  logic [AW-1:0] LOAD_ADDR,
    input  logic [4:0]    LOAD_DATA,
    input  logic [AW:0]   LOAD_LEN,
    output logic [4:0]    PT_DATA,
    output logic          PT_STROBE,
    output logic          PT_STOP,
    output logic          PL6_PHOTO_TAPE_REV,
    output logic          PT_EOT,
    output logic          PT_BUSY
);

    localparam int CNT_MAX = (FRAME_CLKS > START_CLKS) ? FRAME_CLKS : START_CLKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] START_LOAD = CW'(START_CLKS - 1);
    localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_CLKS - 1);
    localparam logic [AW:0]   DEPTH_W    = (AW + 1)'(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] FWD   = 3'd2;
    localparam logic [2:0] REVS  = 3'd3;
    localparam logic [2:0] REV   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [AW:0]   position;
    logic [AW:0]   length;
    logic [AW:0]   pos_p1;
    logic [AW:0]   pos_m1;
    logic [AW:0]   len_clamped;
    logic          first_step;
    logic [4:0]    mem [DEPTH];
    logic [4:0]    rd_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;

    assign pos_p1      = position + (AW + 1)'(1);
    assign pos_m1      = position - (AW + 1)'(1);
    assign len_clamped = (LOAD_LEN > DEPTH_W) ? DEPTH_W : LOAD_LEN;
    assign ram_we      = rst && (state == IDLE) && LOAD_WE;

    assign PL6_PHOTO_TAPE_REV = (state == REVS) || (state == REV);
    assign PT_EOT             = (position == length);
    assign PT_BUSY            = (state != IDLE);

    // Share the single RAM port: host writes in IDLE, otherwise look at the frame under (or, reversing, just behind) the head.
    always_comb begin
        ram_addr = position[AW-1:0];
        if (state == IDLE && LOAD_WE) begin
            ram_addr = LOAD_ADDR;
        end else if (state == REVS || state == REV) begin
            ram_addr = pos_m1[AW-1:0];
        end
    end

    // Tape image storage with a registered read; the address is stable well before every frame boundary.
    always_ff @(posedge CLOCK) begin
        if (ram_we) begin
            mem[ram_addr] <= LOAD_DATA;
        end
        rd_data <= mem[ram_addr];
    end

    // Motor and head control: start delay, frame timing, strobes and position tracking.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            position   <= '0;
            length     <= '0;
            first_step <= 1'b0;
            PT_DATA    <= '0;
            PT_STROBE  <= 1'b0;
            PT_STOP    <= 1'b0;
        end else begin
            PT_STROBE <= 1'b0;
            PT_STOP   <= 1'b0;
            case (state)
                IDLE: begin
                    if (LOAD_WE) begin
                        length <= len_clamped;
                    end
                    if (REWIND) begin
                        position <= '0;
                    end
                    if (REV_CMD && position != '0) begin
                        state <= REVS;
                        cnt   <= START_LOAD;
                    end else if (PL6_PHOTO_TAPE_FWD && position < length) begin
                        state <= START;
                        cnt   <= START_LOAD;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        state <= FWD;
                        cnt   <= FRAME_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                REVS: begin
                    if (cnt == '0) begin
                        state      <= REV;
                        cnt        <= FRAME_LOAD;
                        first_step <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FWD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!PL6_PHOTO_TAPE_FWD) begin
                        state <= IDLE;
                    end else begin
                        PT_DATA   <= rd_data;
                        PT_STROBE <= 1'b1;
                        PT_STOP   <= (rd_data == STOP_CODE);
                        position  <= pos_p1;
                        cnt       <= FRAME_LOAD;
                        if (pos_p1 >= length) begin
                            state <= IDLE;
                        end
                    end
                end
                REV: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        position   <= pos_m1;
                        first_step <= 1'b0;
                        cnt        <= FRAME_LOAD;
                        if (pos_m1 == '0 || (rd_data == STOP_CODE && !first_step)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptr_reader.sv
// Scoreboard bench for ptr_reader with short motor timings.
// A tape model predicts every strobe (data, stop flag, arrival cycle); a
// monitor pops the predictions as strobes appear.
module tb_ptr_reader;

    localparam int DEPTH = 16;
    localparam int FRAME = 4;
    localparam int START = 2;
    localparam int AW    = 4;
    localparam int STOP  = 16;

    typedef struct {
        int data;
        int stop;
        int cyc;
    } exp_t;

    logic          CLOCK = 1'b0;
    logic          rst = 1'b0;
    logic          tape_fwd = 1'b0;
    logic          rev_cmd = 1'b0;
    logic          rewind = 1'b0;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [4:0]    load_data = '0;
    logic [AW:0]   load_len = '0;
    logic [4:0]    pt_data;
    logic          pt_strobe;
    logic          pt_stop;
    logic          tape_rev;
    logic          pt_eot;
    logic          pt_busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   tape [DEPTH];
    int   mpos = 0;
    int   mlen = 0;
    exp_t exp_q [$];

    ptr_reader #(
        .DEPTH(DEPTH),
        .FRAME_CLKS(FRAME),
        .START_CLKS(START),
        .STOP_CODE(5'h10)
    ) dut (
        .CLOCK(CLOCK),
        .rst(rst),
        .PL6_PHOTO_TAPE_FWD(tape_fwd),
        .REV_CMD(rev_cmd),
        .REWIND(rewind),
        .LOAD_WE(load_we),
        .LOAD_ADDR(load_addr),
        .LOAD_DATA(load_data),
        .LOAD_LEN(load_len),
        .PT_DATA(pt_data),
        .PT_STROBE(pt_strobe),
        .PT_STOP(pt_stop),
        .PL6_PHOTO_TAPE_REV(tape_rev),
        .PT_EOT(pt_eot),
        .PT_BUSY(pt_busy)
    );

    // Free-running clock.
    always #5 CLOCK = ~CLOCK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rev, input logic rew, input logic we,
                                 input int addr, input int data, input int len);
        rev_cmd   = rev;
        rewind    = rew;
        load_we   = we;
        load_addr = AW'(addr);
        load_data = 5'(data);
        load_len  = (AW + 1)'(len);
    endtask

    task automatic load_frame(input int addr, input int data, input int len);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, data, len);
        @(negedge CLOCK);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        tape[addr] = data;
        mlen = (len > DEPTH) ? DEPTH : len;
        checkOutput("eot_after_load", int'(pt_eot), int'(mpos == mlen));
    endtask

    task automatic rewind_tape();
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
        @(negedge CLOCK);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
        mpos = 0;
        checkOutput("eot_after_rewind", int'(pt_eot), int'(mpos == mlen));
    endtask

    // Hold FWD for n frames (dropping it just after the n-th strobe), optionally poking
    // REWIND and a host write mid-stream, both of which must be ignored.
    task automatic run_forward(input int n, input bit glitch);
        int   r;
        int   k;
        int   c;
        int   e_edge;
        int   last;
        exp_t x;
        r = mlen - mpos;
        c = cyc;
        tape_fwd = 1'b1;
        if (r <= 0) begin
            repeat (3) @(negedge CLOCK);
            checkOutput("busy_at_eot", int'(pt_busy), 0);
            tape_fwd = 1'b0;
            return;
        end
        k = (n < r) ? n : r;
        for (int j = 1; j <= k; j++) begin
            x.data = tape[mpos + j - 1];
            x.stop = int'(x.data == STOP);
            x.cyc  = c + 1 + START + FRAME * j;
            exp_q.push_back(x);
        end
        e_edge = (k == r) ? START + FRAME * r : START + FRAME * (n + 1);
        for (int m = 1; m <= e_edge + 1; m++) begin
            @(negedge CLOCK);
            last = m - 1;
            if (glitch && last == START + 1) begin
                applyStimulus(1'b0, 1'b1, 1'b1, mpos, (~tape[mpos]) & 31, $urandom_range(0, 31));
            end else if (glitch && last == START + 2) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
            end
            if (last == START + FRAME * n) tape_fwd = 1'b0;
            if (last == e_edge - 1) checkOutput("busy_before_stop", int'(pt_busy), 1);
            if (last == e_edge) begin
                checkOutput("busy_after_stop", int'(pt_busy), 0);
                break;
            end
        end
        tape_fwd = 1'b0;
        mpos += k;
        checkOutput("eot_after_forward", int'(pt_eot), int'(mpos == mlen));
    endtask

    // Reverse to the previous stop code; with_fwd also raises FWD with the command and
    // holds it for the whole reverse, which must be ignored.
    task automatic run_reverse(input bit with_fwd);
        int p;
        int steps;
        int e_edge;
        int last;
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
        if (mpos == 0) begin
            @(negedge CLOCK);
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
            checkOutput("rev_at_start", int'(tape_rev), 0);
            return;
        end
        tape_fwd = with_fwd;
        p = mpos;
        steps = 0;
        do begin
            p--;
            steps++;
        end while (!(p == 0 || (tape[p] == STOP && steps > 1)));
        e_edge = START + FRAME * steps;
        for (int m = 1; m <= e_edge + 1; m++) begin
            @(negedge CLOCK);
            last = m - 1;
            if (m == 1) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
            if (last == 0) checkOutput("rev_flag_start", int'(tape_rev), 1);
            if (last == e_edge - 1) begin
                checkOutput("rev_flag_end", int'(tape_rev), 1);
                tape_fwd = 1'b0;
            end
            if (last == e_edge) begin
                checkOutput("rev_flag_cleared", int'(tape_rev), 0);
                checkOutput("busy_after_reverse", int'(pt_busy), 0);
                break;
            end
        end
        mpos = p;
        checkOutput("eot_after_reverse", int'(pt_eot), int'(mpos == mlen));
    endtask

    // Reset in the middle of the second frame: motion aborts, length and position clear.
    task automatic reset_mid_frame();
        exp_t x;
        x.data = tape[mpos];
        x.stop = int'(x.data == STOP);
        x.cyc  = cyc + 1 + START + FRAME;
        exp_q.push_back(x);
        tape_fwd = 1'b1;
        repeat (START + FRAME + 2) @(negedge CLOCK);
        rst = 1'b0;
        @(negedge CLOCK);
        rst = 1'b1;
        mpos = 0;
        mlen = 0;
        checkOutput("busy_after_reset", int'(pt_busy), 0);
        checkOutput("strobe_after_reset", int'(pt_strobe), 0);
        checkOutput("data_after_reset", int'(pt_data), 0);
        checkOutput("eot_after_reset", int'(pt_eot), 1);
        checkOutput("rev_after_reset", int'(tape_rev), 0);
        repeat (START + 2 * FRAME) @(negedge CLOCK);
        checkOutput("busy_held_fwd_after_reset", int'(pt_busy), 0);
        tape_fwd = 1'b0;
    endtask

    // Monitor: pops one prediction per strobe and checks data hold between strobes.
    initial begin
        exp_t e;
        int   last_data;
        last_data = 0;
        forever begin
            @(posedge CLOCK);
            cyc++;
            #1;
            if (!rst) last_data = 0;
            if (pt_strobe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_strobe", int'(pt_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("strobe_cycle", cyc, e.cyc);
                    checkOutput("strobe_data", int'(pt_data), e.data);
                    checkOutput("strobe_stop", int'(pt_stop), e.stop);
                    last_data = e.data;
                end
            end else if (cyc > 1) begin
                checkOutput("data_hold", int'(pt_data), last_data);
                if (pt_stop !== 1'b0) checkOutput("stop_without_strobe", int'(pt_stop), 0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (60000) @(posedge CLOCK);
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized tapes and operation sequences.
    initial begin
        int len;
        int len_field;
        int op;
        int data;
        repeat (3) @(negedge CLOCK);
        checkOutput("reset_busy", int'(pt_busy), 0);
        checkOutput("reset_strobe", int'(pt_strobe), 0);
        checkOutput("reset_stop", int'(pt_stop), 0);
        checkOutput("reset_rev", int'(tape_rev), 0);
        checkOutput("reset_eot", int'(pt_eot), 1);
        checkOutput("reset_data", int'(pt_data), 0);
        rst = 1'b1;
        @(negedge CLOCK);

        $display("[TB] three-frame tape read to end");
        load_frame(0, 5'h01, 3);
        load_frame(1, 5'h1F, 3);
        load_frame(2, STOP, 3);
        run_forward(10, 1'b0);

        $display("[TB] FWD dropped after first strobe, then resume");
        rewind_tape();
        run_forward(1, 1'b0);
        run_forward(10, 1'b0);

        $display("[TB] reverse to previous stop code");
        load_frame(0, 5'h02, 4);
        load_frame(1, STOP, 4);
        load_frame(2, 5'h03, 4);
        load_frame(3, 5'h04, 4);
        rewind_tape();
        run_forward(10, 1'b0);
        run_reverse(1'b0);
        run_forward(1, 1'b0);

        $display("[TB] reverse and forward together");
        run_reverse(1'b1);
        run_forward(2, 1'b0);

        $display("[TB] host write and rewind while streaming");
        rewind_tape();
        run_forward(2, 1'b1);
        rewind_tape();
        run_forward(4, 1'b0);

        $display("[TB] reset mid-frame");
        rewind_tape();
        reset_mid_frame();
        load_frame(0, tape[0], 4);
        run_forward(2, 1'b0);

        $display("[TB] randomized tapes");
        for (int iter = 0; iter < 4; iter++) begin
            len = $urandom_range(3, DEPTH);
            len_field = (iter == 0) ? $urandom_range(DEPTH + 1, 31) : len;
            for (int a = 0; a < DEPTH; a++) begin
                data = $urandom_range(0, 31);
                if ($urandom_range(0, 3) == 0) data = STOP;
                load_frame(a, data, len_field);
            end
            rewind_tape();
            for (int s = 0; s < 8; s++) begin
                op = $urandom_range(0, 3);
                if (op <= 1) run_forward($urandom_range(1, 5), 1'b0);
                else if (op == 2) run_reverse(1'($urandom_range(0, 1)));
                else rewind_tape();
            end
        end

        repeat (5) @(negedge CLOCK);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
